// File: rtl/stream_demux_1_4_if.sv
// Handshake bundle for the 1-to-4 stream demultiplexer.
// Upstream side : rr_mode, up_valid, up_ready, up_data, up_sel
// Downstream    : dn_valid[3:0], dn_ready[3:0], dn_data0..dn_data3
// Debug         : rr_ptr (current round-robin pointer)
// The slave modport is the demux view; the master modport is the
// producer/consumer (environment) view.
interface stream_demux_1_4_if #(
    parameter int W = 4
);
    logic         rr_mode;
    logic         up_valid;
    logic         up_ready;
    logic [W-1:0] up_data;
    logic [1:0]   up_sel;
    logic [3:0]   dn_valid;
    logic [3:0]   dn_ready;
    logic [W-1:0] dn_data0;
    logic [W-1:0] dn_data1;
    logic [W-1:0] dn_data2;
    logic [W-1:0] dn_data3;
    logic [1:0]   rr_ptr;

    modport slave (
        input  rr_mode, up_valid, up_data, up_sel, dn_ready,
        output up_ready, dn_valid, dn_data0, dn_data1, dn_data2, dn_data3, rr_ptr
    );

    modport master (
        output rr_mode, up_valid, up_data, up_sel, dn_ready,
        input  up_ready, dn_valid, dn_data0, dn_data1, dn_data2, dn_data3, rr_ptr
    );
endinterface

// File: rtl/stream_demux_1_4.sv
// 1-to-4 streaming demultiplexer with one registered holding stage per lane.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset (clears lane flags, data, pointer)
//   bus - stream_demux_1_4_if.slave: upstream handshake + select/mode,
//         four downstream lanes, and the round-robin pointer for debug.
// Target lane is up_sel (rr_mode=0) or the internal pointer (rr_mode=1).
// A lane is free when empty or being drained this cycle, so a lane can be
// drained and refilled in the same cycle. up_ready is combinational from
// the lane state and dn_ready; it never looks at up_valid.
module stream_demux_1_4 #(
    parameter int W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    stream_demux_1_4_if.slave      bus
);
    logic [3:0]   dn_valid_q;
    logic [3:0]   dn_valid_d;
    logic [W-1:0] dn_data_q [4];
    logic [W-1:0] dn_data_d [4];
    logic [1:0]   rr_ptr_q;
    logic [1:0]   rr_ptr_d;

    logic [1:0]   tgt_s;
    logic [3:0]   free_s;
    logic [3:0]   load_s;
    logic         up_ready_s;
    logic         accept_s;

    // Target selection, lane-free status and upstream acceptance.
    always_comb begin
        tgt_s = 2'd0;
        if (bus.rr_mode) begin
            tgt_s = rr_ptr_q;
        end else begin
            tgt_s = bus.up_sel;
        end
        free_s     = ~dn_valid_q | bus.dn_ready;
        up_ready_s = free_s[tgt_s];
        accept_s   = bus.up_valid & up_ready_s;
        load_s     = 4'b0000;
        if (accept_s) begin
            load_s = 4'b0001 << tgt_s;
        end else begin
            load_s = 4'b0000;
        end
    end

    // Next-state for lane flags/data and the round-robin pointer.
    always_comb begin
        dn_valid_d = dn_valid_q;
        for (int i = 0; i < 4; i++) begin
            dn_data_d[i] = dn_data_q[i];
            if (load_s[i]) begin
                dn_valid_d[i] = 1'b1;
                dn_data_d[i]  = bus.up_data;
            end else begin
                // Drain clears the flag only; data is left as is.
                dn_valid_d[i] = dn_valid_q[i] & ~bus.dn_ready[i];
                dn_data_d[i]  = dn_data_q[i];
            end
        end
        if (accept_s && bus.rr_mode) begin
            rr_ptr_d = rr_ptr_q + 2'd1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid_q <= 4'b0000;
            rr_ptr_q   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                dn_data_q[i] <= {W{1'b0}};
            end
        end else begin
            dn_valid_q <= dn_valid_d;
            rr_ptr_q   <= rr_ptr_d;
            for (int i = 0; i < 4; i++) begin
                dn_data_q[i] <= dn_data_d[i];
            end
        end
    end

    assign bus.up_ready = up_ready_s;
    assign bus.dn_valid = dn_valid_q;
    assign bus.dn_data0 = dn_data_q[0];
    assign bus.dn_data1 = dn_data_q[1];
    assign bus.dn_data2 = dn_data_q[2];
    assign bus.dn_data3 = dn_data_q[3];
    assign bus.rr_ptr   = rr_ptr_q;
endmodule

// File: tb/tb_stream_demux_1_4.sv
// Self-checking bench for stream_demux_1_4: directed scenarios followed by
// a randomized phase, all compared against a lane-level reference model.
module tb_stream_demux_1_4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stream_demux_1_4_if #(.W(W)) bus();

    stream_demux_1_4 #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: each lane is a one-entry slot, pointer is a counter mod 4.
    bit         m_full [4];
    logic [3:0] m_data [4];
    int         m_ptr;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = 4'h0;
        end
        m_ptr = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_valid_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_full[i];
        return v;
    endfunction

    task automatic check_outputs();
        chk("dn_valid", {28'd0, bus.dn_valid}, {28'd0, model_valid_vec()});
        chk("dn_data0", {28'd0, bus.dn_data0}, {28'd0, m_data[0]});
        chk("dn_data1", {28'd0, bus.dn_data1}, {28'd0, m_data[1]});
        chk("dn_data2", {28'd0, bus.dn_data2}, {28'd0, m_data[2]});
        chk("dn_data3", {28'd0, bus.dn_data3}, {28'd0, m_data[3]});
        chk("rr_ptr",   {30'd0, bus.rr_ptr},   m_ptr);
    endtask

    // One clock cycle: drive, check up_ready, clock, update model, check outputs.
    task automatic cyc(input bit mode, input bit v, input logic [3:0] d,
                       input logic [1:0] sel, input logic [3:0] rdy);
        int  tgt;
        bit  exp_ready;
        bus.rr_mode  = mode;
        bus.up_valid = v;
        bus.up_data  = d;
        bus.up_sel   = sel;
        bus.dn_ready = rdy;
        #1;
        tgt       = mode ? m_ptr : int'(sel);
        exp_ready = !m_full[tgt] || rdy[tgt];
        chk("up_ready", {31'd0, bus.up_ready}, {31'd0, exp_ready});
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (m_full[i] && rdy[i]) m_full[i] = 1'b0;
        end
        if (v && exp_ready) begin
            m_full[tgt] = 1'b1;
            m_data[tgt] = d;
            if (mode) m_ptr = (m_ptr + 1) % 4;
        end
        #1;
        check_outputs();
    endtask

    initial begin
        bus.rr_mode  = 1'b0;
        bus.up_valid = 1'b0;
        bus.up_data  = 4'h0;
        bus.up_sel   = 2'd0;
        bus.dn_ready = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset then idle: empty lanes, pointer 0, ready for every select.
        chk("rst_dn_valid", {28'd0, bus.dn_valid}, 32'd0);
        chk("rst_rr_ptr", {30'd0, bus.rr_ptr}, 32'd0);
        check_outputs();
        for (int s = 0; s < 4; s++) begin
            bus.up_sel = 2'(s);
            #1;
            chk("idle_up_ready", {31'd0, bus.up_ready}, 32'd1);
        end

        // Mode 0, all ready: A,B,C,D to lanes 2,0,3,1.
        cyc(1'b0, 1'b1, 4'hA, 2'd2, 4'hF);
        chk("A_lane2", {28'd0, bus.dn_valid, bus.dn_data2}, {24'd0, 4'b0100, 4'hA});
        cyc(1'b0, 1'b1, 4'hB, 2'd0, 4'hF);
        chk("B_lane0", {28'd0, bus.dn_valid, bus.dn_data0}, {24'd0, 4'b0001, 4'hB});
        cyc(1'b0, 1'b1, 4'hC, 2'd3, 4'hF);
        chk("C_lane3", {28'd0, bus.dn_valid, bus.dn_data3}, {24'd0, 4'b1000, 4'hC});
        cyc(1'b0, 1'b1, 4'hD, 2'd1, 4'hF);
        chk("D_lane1", {28'd0, bus.dn_valid, bus.dn_data1}, {24'd0, 4'b0010, 4'hD});
        chk("mode0_ptr", {30'd0, bus.rr_ptr}, 32'd0);
        cyc(1'b0, 1'b0, 4'h0, 2'd0, 4'hF);

        // Mode 0 stall on lane 1.
        cyc(1'b0, 1'b1, 4'h5, 2'd1, 4'b1101);
        cyc(1'b0, 1'b1, 4'h6, 2'd1, 4'b1101);
        chk("stall_data1", {28'd0, bus.dn_data1}, 32'h5);
        bus.up_sel = 2'd1;
        #1;
        chk("stall_up_ready", {31'd0, bus.up_ready}, 32'd0);
        cyc(1'b0, 1'b1, 4'h7, 2'd3, 4'b1101);
        chk("other_lane_ok", {28'd0, bus.dn_valid}, {28'd0, 4'b1010});
        cyc(1'b0, 1'b1, 4'h6, 2'd1, 4'hF);
        chk("drain_refill", {28'd0, bus.dn_valid[1], bus.dn_data1}, {27'd0, 1'b1, 4'h6});
        cyc(1'b0, 1'b0, 4'h0, 2'd0, 4'hF);

        // Mode 1, six beats land on lanes 0,1,2,3,0,1.
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, 1'b1, 4'(k), 2'd3, 4'hF);
        end
        chk("rr_ptr_after6", {30'd0, bus.rr_ptr}, 32'd2);
        chk("rr_lane1_last", {28'd0, bus.dn_data1}, 32'h6);

        // Mode 1 strict round-robin: lane 2 full and stalled blocks upstream.
        cyc(1'b1, 1'b1, 4'h9, 2'd0, 4'b1011);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 4'(k + 1), 2'd0, 4'b1011);
        end
        cyc(1'b1, 1'b0, 4'h0, 2'd0, 4'b1011);
        chk("rr_stall_ptr", {30'd0, bus.rr_ptr}, 32'd2);
        bus.up_valid = 1'b1;
        #1;
        chk("rr_strict_block", {31'd0, bus.up_ready}, 32'd0);
        cyc(1'b1, 1'b1, 4'hE, 2'd0, 4'b1011);
        cyc(1'b1, 1'b0, 4'h0, 2'd0, 4'hF);
        cyc(1'b1, 1'b1, 4'hE, 2'd0, 4'hF);
        chk("rr_after_drain", {28'd0, bus.dn_valid, bus.dn_data2}, {24'd0, 4'b0100, 4'hE});

        // Mode switch keeps the pointer.
        chk("ptr_before_switch", {30'd0, bus.rr_ptr}, 32'd3);
        cyc(1'b0, 1'b1, 4'h1, 2'd0, 4'hF);
        cyc(1'b0, 1'b1, 4'h2, 2'd0, 4'hF);
        chk("ptr_held_mode0", {30'd0, bus.rr_ptr}, 32'd3);
        cyc(1'b1, 1'b1, 4'h8, 2'd0, 4'hF);
        chk("resume_lane3", {28'd0, bus.dn_valid, bus.dn_data3}, {24'd0, 4'b1000, 4'h8});

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                4'($urandom), 2'($urandom), 4'($urandom));
        end

        // Fill every lane, then reset asynchronously between edges.
        for (int s = 0; s < 4; s++) begin
            cyc(1'b0, 1'b1, 4'(s + 3), 2'(s), 4'b0000);
        end
        chk("full_before_rst", {28'd0, bus.dn_valid}, 32'hF);
        bus.up_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_valid", {28'd0, bus.dn_valid}, 32'd0);
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b1, 4'h4, 2'd2, 4'hF);
        chk("post_rst_lane0", {28'd0, bus.dn_valid}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
- 1-to-4 streaming demultiplexer with a valid/ready handshake on every side; the sequential counterpart of the 4:1 mux.
- One upstream stream is routed into one registered holding stage per lane.
- Lane selection is either explicit, from a per-beat select, or round-robin, from an internal rotating pointer.
- Sits between a single producer and four independent consumers.

Parameters:
- W, 4, data width of every lane in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- rr_mode  input  1  0 = route by up_sel; 1 = route by internal round-robin pointer.
- up_valid  input  1  upstream beat valid.
- up_ready  output  1  upstream beat accepted this cycle when up_valid & up_ready.
- up_data  input  W  upstream payload.
- up_sel  input  2  target lane when rr_mode = 0; ignored when rr_mode = 1.
- dn_valid  output  4  bit i: lane i holds a beat.
- dn_ready  input  4  bit i: consumer i accepts lane i this cycle.
- dn_data0  output  W  lane 0 payload.
- dn_data1  output  W  lane 1 payload.
- dn_data2  output  W  lane 2 payload.
- dn_data3  output  W  lane 3 payload.
- rr_ptr  output  2  current round-robin pointer, for debug and verification.

Behaviour:
- Reset, asynchronous: dn_valid = 4'b0000, dn_data0..3 = 0, rr_ptr = 0. Reset asserted mid-operation discards all held beats immediately.
- Target lane: tgt = rr_mode ? rr_ptr : up_sel. It is combinational, so rr_mode may change on any cycle.
- Lane i is free when !dn_valid[i] | dn_ready[i]. This allows a full-throughput drain-and-refill in the same cycle.
- up_ready = lane tgt is free.
  - up_ready depends only on rr_mode, up_sel, rr_ptr, dn_valid and dn_ready. It never depends on up_valid.
  - The dn_ready-to-up_ready combinational path is permitted.
- Accept = up_valid & up_ready. On accept, lane tgt loads up_data and dn_valid[tgt] <= 1. Latency is 1 cycle: a beat accepted at edge N appears on dn_data/dn_valid after edge N.
- Drain without load: dn_valid[i] & dn_ready[i] & not loading lane i gives dn_valid[i] <= 0. dn_dataN keeps its last value; it is not cleared.
- Drain and load on the same lane in one cycle: dn_valid[i] stays 1 and dn_dataN takes the new beat.
- Stall: while dn_valid[i] & !dn_ready[i], dn_dataN and dn_valid[i] are held stable.
- Lanes are independent. A stalled lane blocks upstream only when it is the current target. Other lanes keep draining regardless.
- Pointer:
  - rr_ptr advances by 1, wrapping 3 to 0, only on an accept while rr_mode = 1.
  - In mode 0, rr_ptr holds its value. Switching 0 to 1 resumes from the held value, with no reset of the pointer.
- Round-robin is strict: if lane rr_ptr is stalled, upstream waits. The block never skips to another free lane.
- A beat whose up_valid is high while up_ready is low is not consumed. The producer must hold it.
- No state machine beyond the four lane-valid flags and the pointer.

Test Plan:
- Reset then idle: dn_valid = 0000, rr_ptr = 0, up_ready = 1 for any up_sel.
- Mode 0, all dn_ready = 1, beats A,B,C,D with up_sel 2,0,3,1 on consecutive cycles: each beat appears one cycle later on lane 2,0,3,1 respectively. up_ready stays 1 throughout and rr_ptr stays 0.
- Mode 0, dn_ready[1] = 0:
  - Send 5 to lane 1, then 6 to lane 1: 6 stalls with up_ready = 0 and dn_data1 held at 5.
  - A beat 7 sent to lane 3 in the same stall period is accepted.
  - Raising dn_ready[1] drains 5 and loads 6 in the same cycle, with dn_valid[1] staying 1.
- Mode 1, all ready, 6 beats 1..6: they land on lanes 0,1,2,3,0,1 and rr_ptr ends at 2.
- Mode 1, dn_ready[2] = 0 with lane 2 full and rr_ptr = 2: up_ready = 0 even though lanes 0, 1 and 3 are free. Once lane 2 drains, the next beat goes to lane 2.
- Mode switch and reset:
  - Mode 1, rr_ptr = 3; switch to mode 0 and send 2 beats to lane 0: rr_ptr stays 3. Switch back to mode 1: the next beat lands on lane 3.
  - Assert rst with lanes full: dn_valid goes to 0 with no clock edge required.
